// File: rtl/sram_initiator.sv
// sram_initiator: valid/ready request stream to single-port SRAM adapter.
// Read data is captured one cycle after issue into a small response FIFO.
// Reads are only accepted while a FIFO slot is reserved for them. Each
// read in flight or still buffered holds one credit.
module sram_initiator #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RESP_DEPTH = 3,
  localparam int unsigned AW = $clog2(NUM_WORDS),
  localparam int unsigned OW = $clog2(RESP_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [DATA_WIDTH-1:0] req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [DATA_WIDTH-1:0] sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [OW-1:0]         outstanding_o
);

  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RESP_DEPTH - 1);
  localparam logic [OW-1:0] DEPTH_C  = OW'(RESP_DEPTH);

  logic                  rd_pending_q;
  logic [OW-1:0]         count_q;
  logic [OW-1:0]         occ;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
  logic                  issue_rd;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Occupancy is purely registered, so the downstream ready never reaches req_ready_o.
  assign occ           = count_q + OW'(rd_pending_q);
  assign outstanding_o = occ;
  assign req_ready_o   = req_we_i | (occ < DEPTH_C);

  assign sram_req_o   = req_valid_i & req_ready_o;
  assign sram_we_o    = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign issue_rd    = sram_req_o & ~req_we_i;
  assign push        = rd_pending_q;
  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rd_ptr_q] : '0;

  // Read pipeline marker: SRAM data is valid the cycle after a read issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= issue_rd;
    end
  end

  // FIFO pointers and entry count; a simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage. It has no reset because the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= sram_rdata_i;
  end

endmodule
